// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - ECP5 PLL reset/lock sequencer with dynamic phase-step pulse generation
// Optional: define PLL_PHASE_CTRL_RELOCK_EN to re-pulse the PLL reset after every lock loss.
module pll_phase_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int LOCK_FILTER = 1024,
    parameter int STEP_SETUP  = 4,
    parameter int STEP_PULSE  = 4,
    parameter int STEP_GAP    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       step_done,
    output logic       busy,
    output logic [7:0] relock_cnt
);
    localparam int CW = $clog2(RST_CYCLES + LOCK_FILTER + STEP_SETUP + STEP_PULSE + STEP_GAP + 1);

    typedef enum logic [2:0] {
        S_PLLRST, S_WAIT_LOCK, S_FILTER, S_RUN, S_SETUP, S_STEP, S_GAP
    } state_t;

`ifdef PLL_PHASE_CTRL_RELOCK_EN
    localparam state_t LOSS_STATE = S_PLLRST;
`else
    localparam state_t LOSS_STATE = S_WAIT_LOCK;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    steps_q, steps_d;
    logic [7:0]    relock_q, relock_d;
    logic [1:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic          zero_q, zero_d;
    logic          done_q, done_d;
    logic          lock_meta_q, lock_s_q;
    logic          running;
    logic          accept;

    // A lock seen while the PLL is held in reset is stale, so the synchroniser is flushed then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else if (state_q == S_PLLRST) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_PLLRST;
            cnt_q    <= '0;
            steps_q  <= '0;
            relock_q <= '0;
            sel_q    <= '0;
            dir_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            relock_q <= relock_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign running = state_q inside {S_RUN, S_SETUP, S_STEP, S_GAP};
    assign accept  = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        relock_d = relock_q;
        sel_d    = sel_q;
        dir_d    = dir_q;
        zero_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) state_d = S_FILTER;
            end
            S_FILTER: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    sel_d   = req_sel;
                    dir_d   = req_dir;
                    steps_d = req_steps;
                    cnt_d   = '0;
                    if (req_steps == 8'd0) zero_d  = 1'b1;
                    else                   state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(STEP_SETUP - 1)) begin
                    state_d = S_STEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STEP: begin
                if (cnt_q == CW'(STEP_PULSE - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(STEP_GAP - 1)) begin
                    cnt_d   = '0;
                    steps_d = steps_q - 8'd1;
                    if (steps_q == 8'd1) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_PLLRST;
                cnt_d   = '0;
            end
        endcase

        // Lock loss overrides everything, including a request accepted in the same cycle.
        if (running && !lock_s_q) begin
            state_d = LOSS_STATE;
            cnt_d   = '0;
            steps_d = '0;
            sel_d   = sel_q;
            dir_d   = dir_q;
            zero_d  = 1'b0;
            done_d  = 1'b0;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
    end

    assign pll_rst    = (state_q == S_PLLRST);
    assign sys_reset  = !running;
    assign req_ready  = (state_q == S_RUN) && !zero_q;
    assign busy       = (state_q != S_RUN);
    assign phasestep  = (state_q == S_STEP);
    assign phasesel   = sel_q;
    assign phasedir   = dir_q;
    assign step_done  = done_q;
    assign relock_cnt = relock_q;
endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencer for the ECP5 EHXPLLL on the board clock path. Drives PLL reset at power-up and supervises lock with a filtered, synchronised lock detector. Holds the SoC system reset until lock is stable. Once running, it accepts dynamic phase-shift requests and converts each into correctly spaced PHASESEL/PHASEDIR/PHASESTEP pulses. It runs on the free-running PLL input clock, never on a PLL output.

## Interface
Parameters:
- RST_CYCLES, 16 — width of the pll_rst pulse after reset release, in clk cycles
- LOCK_FILTER, 1024 — consecutive synced-lock-high cycles required before release
- STEP_SETUP, 4 — cycles phasesel/phasedir are stable before the first phasestep pulse
- STEP_PULSE, 4 — phasestep high time, in cycles
- STEP_GAP, 8 — phasestep low time after each pulse, in cycles

Ports:
- clk  in  1  PLL reference clock (clki domain)
- reset  in  1  asynchronous, active-high
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk
- pll_rst  out  1  to PLL RST
- sys_reset  out  1  active-high reset for the PLL-clocked logic
- req_valid  in  1  phase-shift request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_sel  in  2  output select: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3
- req_dir  in  1  PLL PHASEDIR value
- req_steps  in  8  number of phase steps; 0 is a legal no-op
- phasesel  out  2  to PHASESEL1:0
- phasedir  out  1  to PHASEDIR
- phasestep  out  1  to PHASESTEP
- step_done  out  1  one-cycle pulse when a nonzero request completes
- busy  out  1  high in every state except RUN
- relock_cnt  out  8  count of lock losses seen in RUN or stepping; saturates at 255

## Operation
- pll_lock passes through a 2-flop synchroniser (lock_s). All decisions use lock_s.
- States and transitions:
  - PLLRST: pll_rst=1 for RST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: when lock_s=1, go to FILTER.
  - FILTER: counts lock_s-high cycles. lock_s=0 clears the count and returns to WAIT_LOCK. At LOCK_FILTER, go to RUN.
  - RUN: req_ready=1, sys_reset=0.
    - On accept, latch sel, dir and steps.
    - steps=0: stay in RUN, req_ready low for exactly 1 cycle, no step_done.
    - steps≠0: go to SETUP.
  - SETUP: STEP_SETUP cycles, then STEP.
  - STEP: phasestep=1 for STEP_PULSE cycles, then GAP.
  - GAP: phasestep=0 for STEP_GAP cycles. Decrement remaining steps. If remaining≠0 go to STEP; otherwise go to RUN and pulse step_done.
- phasesel and phasedir update only on accept. They hold the latched values through SETUP, STEP and GAP and keep them in RUN afterwards.
- Lock loss (lock_s=0) in RUN, SETUP, STEP or GAP:
  - abort any request in progress; phasestep drops to 0 next cycle; no step_done;
  - sys_reset=1 next cycle;
  - relock_cnt increments, saturating at 255;
  - next state is set by the configuration macro.
- reset asserted at any time forces the reset values immediately (asynchronous) and restarts from PLLRST.
- Reset values: pll_rst=1, sys_reset=1, req_ready=0, busy=1, phasestep=0, phasesel=0, phasedir=0, step_done=0, relock_cnt=0; state PLLRST, all counters 0.

## Timing
- Lock synchroniser latency is 2 cycles.
- Power-up with a continuously locked PLL: sys_reset deasserts RST_CYCLES + 2 + LOCK_FILTER + 1 cycles (±1 for WAIT_LOCK entry) after reset falls.
- sys_reset, req_ready and busy change in the same cycle as the RUN entry/exit.
- Request timing, for a request accepted at edge 0 with N steps:
  - the first phasestep rise is at edge STEP_SETUP;
  - step_done pulses at edge STEP_SETUP + N·(STEP_PULSE+STEP_GAP);
  - req_ready returns high in that same cycle.
- A request can be accepted in the cycle step_done is high (back-to-back). The accept cycle itself does not count toward SETUP.
- relock_cnt updates 1 cycle after lock_s falls.

## Configuration
- PLL_PHASE_CTRL_RELOCK_EN defined: on lock loss the FSM goes to PLLRST, re-pulsing pll_rst for RST_CYCLES before WAIT_LOCK.
- Undefined: on lock loss the FSM goes directly to WAIT_LOCK; pll_rst stays 0 after the initial power-up pulse.

## Test plan
- Power-up: RST_CYCLES=4, LOCK_FILTER=8, pll_lock tied 1 -> pll_rst high for 4 cycles; sys_reset falls on the cycle predicted in Timing; req_ready rises in the same cycle.
- Filter glitch: pll_lock drops for 1 cycle at filter count 5 -> the count restarts; sys_reset is released 8 full cycles after lock_s returns high.
- Step request with defaults: sel=2, dir=1, steps=3 -> phasesel=2 and phasedir=1 from the next cycle; exactly 3 phasestep pulses, each 4 cycles high; step_done at edge 4+3·12=40.
- Zero steps: steps=0 -> req_ready low for 1 cycle; no phasestep; no step_done; phasesel updated.
- Lock loss during the 2nd pulse of a 5-step request -> phasestep=0 and sys_reset=1 next cycle; relock_cnt=1; no step_done. With the macro, pll_rst pulses for RST_CYCLES; without it, pll_rst stays 0.
- 300 lock-loss events -> relock_cnt holds at 255; asynchronous reset mid-STEP clears relock_cnt to 0 and restarts the PLLRST sequence.
